scr_stack_ctrl: RTL and testbench
=================================

# scr_stack_ctrl

Stack sequencer that owns the scratch RAM's stack region and the stack pointer. It accepts PUSH/POP/CALL/RET requests from the control unit over a valid/ready handshake and drives the scratch RAM address, write data and write enable. It returns popped data and return addresses, and keeps full/empty/error status. It sits between the control unit, the register file X port, the program counter and the 256x10 scratch RAM, and replaces direct mux-select control of the scratch RAM for stack traffic.

## Interface
- STACK_DEPTH, 64: maximum stack occupancy in words, legal range 1..255; the stack occupies the top STACK_DEPTH addresses.

- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- OP_VALID  in  1  request valid.
- OP  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET.
- OP_READY  out  1  controller can accept a request.
- SP_LD  in  1  load SP from DX_OUT (WSP); honoured only in IDLE.
- DX_OUT  in  8  register-file X data (PUSH data, SP_LD value).
- PC_COUNT  in  10  return address for CALL.
- SCR_DATA_OUT  in  10  scratch RAM asynchronous read data.
- SCR_ADDR  out  8  scratch RAM address.
- SCR_DIN  out  10  scratch RAM write data.
- SCR_WE  out  1  scratch RAM write enable.
- DONE  out  1  one-cycle completion pulse.
- POP_DATA  out  8  popped byte.
- RET_ADDR  out  10  popped return address.
- SP  out  8  stack pointer.
- FULL  out  1  occupancy == STACK_DEPTH.
- EMPTY  out  1  occupancy == 0.
- ERR  out  1  sticky overflow/underflow flag.
- ERR_CLR  in  1  clears ERR.

## Operation
- Occupancy is derived, not counted: occ = (0 − SP) mod 256. SP = 0 means empty, and the first PUSH lands at 0xFF.
- FSM states: IDLE, WR, RD, RESP.
  - OP_READY = (state == IDLE) && !SP_LD.
- In IDLE with SP_LD = 1: SP ← DX_OUT at the next edge; stay in IDLE.
- Accept on OP_VALID && OP_READY. At acceptance, latch OP, {2'b00, DX_OUT} (PUSH) or PC_COUNT (CALL) into the write-data register.
- PUSH/CALL:
  - IDLE → WR.
  - In WR: SCR_ADDR = SP − 1, SCR_DIN = latched data, SCR_WE = 1. SP ← SP − 1 at the end of WR.
  - WR → RESP.
- POP/RET:
  - IDLE → RD.
  - In RD: SCR_ADDR = SP, SCR_WE = 0. Capture SCR_DATA_OUT[7:0] into POP_DATA (POP) or SCR_DATA_OUT into RET_ADDR (RET). SP ← SP + 1 at the end of RD.
  - RD → RESP.
- Overflow: PUSH/CALL accepted while FULL. Underflow: POP/RET accepted while EMPTY. In either case go IDLE → RESP directly, with no RAM access and SP unchanged. ERR sets at the end of the acceptance cycle.
- RESP: DONE = 1, then → IDLE.
- POP_DATA and RET_ADDR hold their values until overwritten by a later POP or RET.
- Outside WR: SCR_WE = 0, SCR_ADDR = SP, SCR_DIN = latched data.
- ERR_CLR clears ERR. If a new error occurs in the same cycle, the set wins.
- SP arithmetic is 8-bit modulo 256.
- Reset: state IDLE, SP = 0x00, POP_DATA = 0, RET_ADDR = 0, SCR_WE = 0, SCR_ADDR = 0x00, SCR_DIN = 0, DONE = 0, ERR = 0, EMPTY = 1, FULL = 0, OP_READY = 1. Reset asserted mid-operation aborts it: any pending write is dropped and SP returns to 0.

## Timing
- Request accepted at edge 0. WR/RD is the cycle after edge 0. DONE is high in the cycle after edge 1. OP_READY returns high the cycle after edge 2.
- Throughput is one operation per 3 cycles. An error operation takes 2 cycles.
- OP_READY is combinational from state and SP_LD. All other outputs except SCR_ADDR and SCR_WE in WR/RD are registered.
- SP, FULL and EMPTY update at the end of WR/RD and are stable during RESP.
- OP, DX_OUT and PC_COUNT are sampled only at acceptance. Changes after acceptance have no effect.

## Configuration
- SCR_STACK_GUARD_EN defined: overflow/underflow detection as above. FULL, EMPTY and ERR are live.
- SCR_STACK_GUARD_EN undefined:
  - No checks. Every operation performs its RAM access, and SP wraps freely modulo 256.
  - STACK_DEPTH is ignored.
  - FULL, ERR = 0 constant; EMPTY = (SP == 0). ERR_CLR is ignored.

## Test plan
- Reset, then PUSH with DX_OUT = 0xA5 → SCR_WE high for one cycle at SCR_ADDR = 0xFF, SCR_DIN = 0x0A5; SP = 0xFF; DONE two cycles after acceptance; EMPTY = 0.
- CALL with PC_COUNT = 0x2C7, then RET → write of 0x2C7 at 0xFE after the prior push; RET_ADDR = 0x2C7; SP back to 0xFF; DONE on each.
- STACK_DEPTH = 4, guard on: 4 PUSHes fill the stack (SP = 0xFC, FULL = 1); a 5th PUSH → no SCR_WE, SP stays 0xFC, ERR = 1, DONE after 2 cycles; ERR_CLR → ERR = 0.
- POP from empty, guard on → ERR = 1, SP stays 0x00, POP_DATA unchanged. With guard off → read at 0x00, SP = 0x01.
- SP_LD with DX_OUT = 0x80 while OP_VALID is high → OP_READY low that cycle, SP = 0x80; the next PUSH writes 0x7F.
- RST_N asserted during the WR cycle of a PUSH → no write committed after reset, SP = 0x00, DONE never pulses, OP_READY = 1 on release.

Source files
------------

// File: rtl/scr_stack_ctrl_if.sv
// Stack controller bus: control-unit request/response and scratch RAM port.
// Latency: none (bundle of wires only).
// Backpressure: op_valid/op_ready handshake; the controller drops op_ready while busy or during sp_ld.
//
// Request side:  op_valid, op, op_ready, sp_ld, dx_out, pc_count, err_clr
// Response side: done, pop_data, ret_addr, sp, full, empty, err
// RAM side:      scr_addr, scr_din, scr_we, scr_data_out (asynchronous read data)
interface scr_stack_ctrl_if;
  logic       op_valid;
  logic [1:0] op;
  logic       op_ready;
  logic       sp_ld;
  logic [7:0] dx_out;
  logic [9:0] pc_count;
  logic       err_clr;

  logic       done;
  logic [7:0] pop_data;
  logic [9:0] ret_addr;
  logic [7:0] sp;
  logic       full;
  logic       empty;
  logic       err;

  logic [7:0] scr_addr;
  logic [9:0] scr_din;
  logic       scr_we;
  logic [9:0] scr_data_out;

  // Environment side: control unit, register file, PC and scratch RAM.
  modport master (
    output op_valid, op, sp_ld, dx_out, pc_count, err_clr, scr_data_out,
    input  op_ready, done, pop_data, ret_addr, sp, full, empty, err,
           scr_addr, scr_din, scr_we
  );

  // Stack controller side.
  modport slave (
    input  op_valid, op, sp_ld, dx_out, pc_count, err_clr, scr_data_out,
    output op_ready, done, pop_data, ret_addr, sp, full, empty, err,
           scr_addr, scr_din, scr_we
  );
endinterface

// File: rtl/scr_stack_ctrl.sv
// Stack sequencer owning the scratch RAM stack region and stack pointer (PUSH/POP/CALL/RET).
// Latency: accept -> WR/RD -> RESP (done pulse); 3 cycles per op, 2 cycles for a guarded error op.
// Backpressure: op_ready only in IDLE and only when sp_ld is low; requests are held off otherwise.
//
// Ports: clk, rst_n (async, active low), bus (scr_stack_ctrl_if.slave).
// Build option: define SCR_STACK_GUARD_EN to enable overflow/underflow detection
// (full/err live, STACK_DEPTH honoured). Without it the stack wraps freely mod 256.
module scr_stack_ctrl #(
  parameter int STACK_DEPTH = 64  // words, 1..255; stack occupies the top STACK_DEPTH addresses
) (
  input  logic            clk,
  input  logic            rst_n,
  scr_stack_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // Opcodes; PUSH is 2'b00 (the only remaining write op besides CALL).
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam logic [7:0] DEPTH = 8'(STACK_DEPTH);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] sp;
  logic [1:0] op_q;
  logic [9:0] wdata;
  logic [7:0] pop_data;
  logic [9:0] ret_addr;
  logic       done;
  logic       full;
  logic       empty;
  logic       err;
  logic       accept;
  logic       is_read;
  logic       guard_trip;

  assign bus.op_ready = (state == S_IDLE) && !bus.sp_ld;
  assign accept       = bus.op_valid && bus.op_ready;
  assign is_read      = (bus.op == OP_POP) || (bus.op == OP_RET);

`ifdef SCR_STACK_GUARD_EN
  // Occupancy is derived from SP: empty stack has SP = 0, first push lands at 0xFF.
  logic [7:0] occ;
  assign occ        = 8'd0 - sp;
  assign full       = (occ == DEPTH);
  assign empty      = (sp == 8'd0);
  assign guard_trip = accept && (is_read ? empty : full);

  // Sticky error; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (guard_trip) begin
      err <= 1'b1;
    end else if (bus.err_clr) begin
      err <= 1'b0;
    end
  end
`else
  assign full       = 1'b0;
  assign empty      = (sp == 8'd0);
  assign guard_trip = 1'b0;
  assign err        = 1'b0;

  // Depth and err_clr have no function when the guard is compiled out.
  logic unused_cfg;
  assign unused_cfg = &{1'b0, DEPTH, bus.err_clr, 1'b0};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (guard_trip)   state_nxt = S_RESP;  // error: skip the RAM access entirely
          else if (is_read) state_nxt = S_RD;
          else              state_nxt = S_WR;
        end
      end
      S_WR, S_RD: state_nxt = S_RESP;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sp       <= 8'h00;
      op_q     <= 2'b00;
      wdata    <= 10'h000;
      pop_data <= 8'h00;
      ret_addr <= 10'h000;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      // Registered so the pulse lines up with the RESP cycle.
      done  <= (state_nxt == S_RESP);

      if ((state == S_IDLE) && bus.sp_ld) begin
        sp <= bus.dx_out;
      end else if (state == S_WR) begin
        sp <= sp - 8'd1;
      end else if (state == S_RD) begin
        sp <= sp + 8'd1;
      end

      // Request fields are sampled only here; later input changes are ignored.
      if (accept) begin
        op_q <= bus.op;
        if (!is_read) begin
          wdata <= (bus.op == OP_CALL) ? bus.pc_count : {2'b00, bus.dx_out};
        end
      end

      if (state == S_RD) begin
        if (op_q == OP_RET) begin
          ret_addr <= bus.scr_data_out;
        end else begin
          pop_data <= bus.scr_data_out[7:0];
        end
      end
    end
  end

  // Predecrement on write: the slot below SP is addressed during WR.
  assign bus.scr_we   = (state == S_WR);
  assign bus.scr_addr = (state == S_WR) ? (sp - 8'd1) : sp;
  assign bus.scr_din  = wdata;

  assign bus.done     = done;
  assign bus.pop_data = pop_data;
  assign bus.ret_addr = ret_addr;
  assign bus.sp       = sp;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.err      = err;

endmodule

// File: tb/tb_scr_stack_ctrl.sv
// Testbench for scr_stack_ctrl: directed cases with literal expectations, then random traffic.
// A transaction-level model predicts every output each cycle; a scratch RAM fixture serves reads.
// Works with and without SCR_STACK_GUARD_EN defined.
module tb_scr_stack_ctrl;

  localparam int DEPTH = 4;
`ifdef SCR_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] POP  = 2'b01;
  localparam logic [1:0] CALL = 2'b10;
  localparam logic [1:0] RET  = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scr_stack_ctrl_if dif ();

  scr_stack_ctrl #(.STACK_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scratch RAM fixture (asynchronous read, synchronous write) and the model's view of it.
  logic [9:0] ram     [256];
  logic [9:0] ref_mem [256];
  assign dif.scr_data_out = ram[dif.scr_addr];
  always @(posedge clk) if (dif.scr_we === 1'b1) ram[dif.scr_addr] = dif.scr_din;

  // Expected outputs for one non-idle cycle.
  typedef struct {
    bit       we;
    bit [7:0] addr;
    bit [9:0] din;
    bit       done;
    bit [7:0] sp;
    bit [7:0] pop;
    bit [9:0] ret;
  } cyc_t;

  cyc_t     q[$];
  bit [7:0] m_sp;
  bit [9:0] m_din;
  bit [7:0] m_pop;
  bit [9:0] m_ret;
  bit       m_err;
  bit       m_idle;
  bit       m_trip;

  function automatic cyc_t mk(bit we, bit [7:0] addr, bit done);
    cyc_t c;
    c.we = we; c.addr = addr; c.din = m_din; c.done = done;
    c.sp = m_sp; c.pop = m_pop; c.ret = m_ret;
    return c;
  endfunction

  // Turn one accepted request into its cycle-by-cycle schedule.
  task automatic model_accept(input bit [1:0] op, input bit [7:0] dx, input bit [9:0] pc,
                              output bit trip);
    bit rd;
    int occ;
    rd   = op[0];
    occ  = (256 - int'(m_sp)) % 256;
    trip = GUARD && (rd ? (occ == 0) : (occ == DEPTH));
    if (!rd) m_din = op[1] ? pc : {2'b00, dx};
    if (trip) begin
      q.push_back(mk(1'b0, m_sp, 1'b1));
    end else if (!rd) begin
      q.push_back(mk(1'b1, 8'(m_sp - 8'd1), 1'b0));
      m_sp = m_sp - 8'd1;
      q.push_back(mk(1'b0, m_sp, 1'b1));
    end else begin
      q.push_back(mk(1'b0, m_sp, 1'b0));
      if (op[1]) m_ret = ref_mem[m_sp];
      else       m_pop = ref_mem[m_sp][7:0];
      m_sp = m_sp + 8'd1;
      q.push_back(mk(1'b0, m_sp, 1'b1));
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_sp = 8'h00; m_din = 10'h000; m_pop = 8'h00; m_ret = 10'h000; m_err = 1'b0;
    end else begin
      m_idle = (q.size() == 0);
      m_trip = 1'b0;
      if (!m_idle) begin
        if (q[0].we) ref_mem[q[0].addr] = q[0].din;  // write commits at the end of its cycle
        void'(q.pop_front());
      end
      if (m_idle && dif.sp_ld) m_sp = dif.dx_out;
      else if (m_idle && dif.op_valid) model_accept(dif.op, dif.dx_out, dif.pc_count, m_trip);
      if (GUARD) begin
        if (m_trip) m_err = 1'b1;
        else if (dif.err_clr) m_err = 1'b0;
      end
    end
  end

  cyc_t e;
  bit   c_busy;
  int   c_occ;
  always @(negedge clk) begin
    c_busy = (q.size() != 0);
    if (c_busy) e = q[0];
    else        e = mk(1'b0, m_sp, 1'b0);
    c_occ = (256 - int'(e.sp)) % 256;
    chk("op_ready", dif.op_ready, !c_busy && !dif.sp_ld);
    chk("scr_we",   dif.scr_we,   e.we);
    chk("scr_addr", dif.scr_addr, e.addr);
    chk("scr_din",  dif.scr_din,  e.din);
    chk("done",     dif.done,     e.done);
    chk("sp",       dif.sp,       e.sp);
    chk("pop_data", dif.pop_data, e.pop);
    chk("ret_addr", dif.ret_addr, e.ret);
    chk("full",     dif.full,     GUARD && (c_occ == DEPTH));
    chk("empty",    dif.empty,    e.sp == 8'h00);
    chk("err",      dif.err,      m_err);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for op_ready, present one request for exactly one edge, then scramble
  // the request fields. Returns at the start of the cycle following acceptance.
  task automatic issue(input logic [1:0] op, input logic [7:0] dx, input logic [9:0] pc);
    int n;
    n = 0;
    while (dif.op_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("issue_ready", dif.op_ready, 1'b1);
    dif.op_valid = 1'b1; dif.op = op; dif.dx_out = dx; dif.pc_count = pc;
    step();
    dif.op_valid = 1'b0;
    dif.op       = 2'($urandom);
    dif.dx_out   = 8'($urandom);
    dif.pc_count = 10'($urandom);
  endtask

  initial begin
    dif.op_valid = 1'b0; dif.op = PUSH; dif.sp_ld = 1'b0;
    dif.dx_out = 8'h00; dif.pc_count = 10'h000; dif.err_clr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 10'($urandom);
      ref_mem[i] = ram[i];
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sp",    dif.sp,       8'h00);
    chk("rst_empty", dif.empty,    1'b1);
    chk("rst_ready", dif.op_ready, 1'b1);
    chk("rst_we",    dif.scr_we,   1'b0);
    rst_n = 1'b1;
    step();

    // PUSH 0xA5 onto an empty stack
    issue(PUSH, 8'hA5, 10'h000);
    chk("push_we",   dif.scr_we,   1'b1);
    chk("push_addr", dif.scr_addr, 8'hFF);
    chk("push_din",  dif.scr_din,  10'h0A5);
    step();
    chk("push_done", dif.done,     1'b1);
    chk("push_sp",   dif.sp,       8'hFF);
    chk("push_empty", dif.empty,   1'b0);
    step();

    // CALL then RET
    issue(CALL, 8'h00, 10'h2C7);
    chk("call_addr", dif.scr_addr, 8'hFE);
    chk("call_din",  dif.scr_din,  10'h2C7);
    step();
    chk("call_done", dif.done,     1'b1);
    step();
    issue(RET, 8'h00, 10'h000);
    step();
    chk("ret_addr",  dif.ret_addr, 10'h2C7);
    chk("ret_sp",    dif.sp,       8'hFF);
    chk("ret_done",  dif.done,     1'b1);
    step();

    // POP the original byte back
    issue(POP, 8'h00, 10'h000);
    step();
    chk("pop_data",  dif.pop_data, 8'hA5);
    chk("pop_sp",    dif.sp,       8'h00);
    step();

`ifdef SCR_STACK_GUARD_EN
    for (int i = 0; i < DEPTH; i++) begin
      issue(PUSH, 8'(8'h10 + i), 10'h000);
      step();
      step();
    end
    chk("fill_sp",   dif.sp,       8'hFC);
    chk("fill_full", dif.full,     1'b1);
    issue(PUSH, 8'h33, 10'h000);
    chk("ovf_we",    dif.scr_we,   1'b0);
    chk("ovf_done",  dif.done,     1'b1);
    chk("ovf_err",   dif.err,      1'b1);
    step();
    chk("ovf_sp",    dif.sp,       8'hFC);
    chk("ovf_ready", dif.op_ready, 1'b1);
    dif.err_clr = 1'b1;
    step();
    dif.err_clr = 1'b0;
    chk("err_clr",   dif.err,      1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      issue(POP, 8'h00, 10'h000);
      step();
      step();
    end
    issue(POP, 8'h00, 10'h000);
    chk("udf_err",   dif.err,      1'b1);
    chk("udf_done",  dif.done,     1'b1);
    step();
    chk("udf_sp",    dif.sp,       8'h00);
    chk("udf_pop",   dif.pop_data, 8'h10);
    dif.err_clr = 1'b1;
    step();
    dif.err_clr = 1'b0;
`else
    issue(POP, 8'h00, 10'h000);
    chk("wrap_addr", dif.scr_addr, 8'h00);
    chk("wrap_we",   dif.scr_we,   1'b0);
    step();
    chk("wrap_sp",   dif.sp,       8'h01);
    chk("wrap_err",  dif.err,      1'b0);
    step();
`endif

    // SP load wins over a simultaneous request
    dif.sp_ld = 1'b1; dif.dx_out = 8'h80; dif.op_valid = 1'b1; dif.op = PUSH;
    #1;
    chk("spld_ready", dif.op_ready, 1'b0);
    step();
    dif.sp_ld = 1'b0; dif.op_valid = 1'b0;
    chk("spld_sp",   dif.sp,       8'h80);
    issue(PUSH, 8'h5A, 10'h000);
    chk("spld_addr", dif.scr_addr, 8'h7F);
    step();
    step();

    // Reset in the middle of a PUSH write cycle
    issue(PUSH, 8'h77, 10'h000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstwr_we",   dif.scr_we, 1'b0);
    chk("rstwr_sp",   dif.sp,     8'h00);
    chk("rstwr_done", dif.done,   1'b0);
    step();
    step();
    rst_n = 1'b1;
    chk("rstwr_ready", dif.op_ready, 1'b1);
    step();

    // Random traffic
    repeat (2500) begin
      dif.op_valid = ($urandom_range(0, 99) < 60);
      dif.op       = 2'($urandom);
      dif.pc_count = 10'($urandom);
      dif.sp_ld    = ($urandom_range(0, 99) < 4);
      dif.err_clr  = ($urandom_range(0, 99) < 10);
      if (dif.sp_ld) dif.dx_out = 8'((256 - $urandom_range(0, DEPTH + 1)) % 256);
      else           dif.dx_out = 8'($urandom);
      step();
    end
    dif.op_valid = 1'b0; dif.sp_ld = 1'b0; dif.err_clr = 1'b0;
    repeat (4) step();

    for (int i = 0; i < 256; i++) chk("ram_image", ram[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
